// File: rtl/up_down_counter_mod.sv
// up_down_counter_mod: up/down counter over 0..MOD_MAX with programmable step,
// wrap or saturate boundary handling, synchronous load, count enable,
// boundary decode, and overflow/underflow event pulses with sticky flags.
module up_down_counter_mod #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MOD_MAX   = 2**WIDTH-1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             upordown,
  input  logic [WIDTH-1:0] step,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             ovf,
  output logic             unf,
  output logic             ovf_sticky,
  output logic             unf_sticky
);

  // Arithmetic runs one bit wider than the count so sums never truncate.
  localparam logic [WIDTH:0]   C_MAX   = (WIDTH+1)'(MOD_MAX);
  localparam logic [WIDTH:0]   C_WRAP  = (WIDTH+1)'(MOD_MAX + 1);
  localparam logic [WIDTH-1:0] C_MAX_W = WIDTH'(MOD_MAX);
  localparam logic [WIDTH-1:0] C_RST   = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;
  logic             r_ovf_sticky;
  logic             r_unf_sticky;

  logic [WIDTH:0]   w_cnt_ext;
  logic [WIDTH:0]   w_s_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;

  // Widened operands: count, step clamped to MOD_MAX, and their sum.
  always_comb begin
    w_cnt_ext = {1'b0, r_count};
    w_s_ext   = ({1'b0, step} > C_MAX) ? C_MAX : {1'b0, step};
    w_sum     = w_cnt_ext + w_s_ext;
  end

  // Next count and event selection: load beats enable beats hold.
  always_comb begin
    w_count_nxt = r_count;
    w_ovf_nxt   = 1'b0;
    w_unf_nxt   = 1'b0;
    if (load) begin
      w_count_nxt = ({1'b0, load_val} > C_MAX) ? C_MAX_W : load_val;
    end else if (en) begin
      if (upordown) begin
        if (w_sum > C_MAX) begin
          w_ovf_nxt   = 1'b1;
          w_count_nxt = sat_mode ? C_MAX_W : WIDTH'(w_sum - C_WRAP);
        end else begin
          w_count_nxt = WIDTH'(w_sum);
        end
      end else begin
        if (w_s_ext > w_cnt_ext) begin
          w_unf_nxt   = 1'b1;
          w_count_nxt = sat_mode ? '0 : WIDTH'(w_cnt_ext + C_WRAP - w_s_ext);
        end else begin
          w_count_nxt = WIDTH'(w_cnt_ext - w_s_ext);
        end
      end
    end
  end

  // Count, event pulses and sticky flags; a new event beats clr_flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count      <= C_RST;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_unf_sticky <= 1'b0;
    end else begin
      r_count      <= w_count_nxt;
      r_ovf        <= w_ovf_nxt;
      r_unf        <= w_unf_nxt;
      r_ovf_sticky <= (r_ovf_sticky & ~clr_flags) | w_ovf_nxt;
      r_unf_sticky <= (r_unf_sticky & ~clr_flags) | w_unf_nxt;
    end
  end

  // Boundary decode looks at the registered count only.
  always_comb begin
    count      = r_count;
    at_max     = (r_count == C_MAX_W);
    at_min     = (r_count == '0);
    ovf        = r_ovf;
    unf        = r_unf;
    ovf_sticky = r_ovf_sticky;
    unf_sticky = r_unf_sticky;
  end

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Directed bench for up_down_counter_mod (WIDTH=4, MOD_MAX=9). Each vector
// pushes its hand-computed post-edge response; a monitor pops and compares.
module tb_up_down_counter_mod;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, upordown, sat_mode, load, clr_flags;
  logic [3:0] step, load_val;

  logic [3:0] count, count5;
  logic       at_max, at_min, ovf, unf, ovf_sticky, unf_sticky;
  logic       at_max5, at_min5, ovf5, unf5, ovf_sticky5, unf_sticky5;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      nm;
    logic [3:0] c;
    logic       ov, un, os, us;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  up_down_counter_mod #(.WIDTH(4), .MOD_MAX(9), .RESET_VAL(0)) dut (
    .clk(clk), .reset(reset), .en(en), .upordown(upordown), .step(step),
    .sat_mode(sat_mode), .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .count(count), .at_max(at_max), .at_min(at_min), .ovf(ovf), .unf(unf),
    .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
  );

  up_down_counter_mod #(.WIDTH(4), .MOD_MAX(9), .RESET_VAL(5)) dut5 (
    .clk(clk), .reset(reset), .en(en), .upordown(upordown), .step(step),
    .sat_mode(sat_mode), .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .count(count5), .at_max(at_max5), .at_min(at_min5), .ovf(ovf5), .unf(unf5),
    .ovf_sticky(ovf_sticky5), .unf_sticky(unf_sticky5)
  );

  // Compare the full observable state against an expected tuple.
  task automatic check_state(input string nm, input logic [3:0] c,
                             input logic ov, un, os, us);
    logic [9:0] act, req;
    act = {count, ovf, unf, ovf_sticky, unf_sticky, at_max, at_min};
    req = {c, ov, un, os, us, (c == 4'd9), (c == 4'd0)};
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d ovf=%b unf=%b os=%b us=%b max=%b min=%b, want cnt=%0d ovf=%b unf=%b os=%b us=%b max=%b min=%b",
               nm, act[9:6], act[5], act[4], act[3], act[2], act[1], act[0],
               req[9:6], req[5], req[4], req[3], req[2], req[1], req[0]);
    end
  endtask

  // Monitor: every edge with a pending expectation is checked just after it.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check_state(e.nm, e.c, e.ov, e.un, e.os, e.us);
    end
  end

  // Drive one vector ahead of the next edge and queue its expected result.
  task automatic drv(input string nm, input bit i_en, i_up, input int i_step,
                     input bit i_sat, i_ld, input int i_lv, input bit i_clr,
                     input int c, input bit ov, un, os, us);
    exp_t e;
    @(negedge clk);
    en        = i_en;
    upordown  = i_up;
    step      = 4'(i_step);
    sat_mode  = i_sat;
    load      = i_ld;
    load_val  = 4'(i_lv);
    clr_flags = i_clr;
    e.nm = nm; e.c = 4'(c); e.ov = ov; e.un = un; e.os = os; e.us = us;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    en = 0; upordown = 0; step = 0; sat_mode = 0;
    load = 0; load_val = 0; clr_flags = 0;
  endtask

  task automatic check5(input string nm, input logic [3:0] want);
    n_tests++;
    if (count5 !== want) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d, want cnt=%0d", nm, count5, want);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_state("reset_state", 4'd0, 0, 0, 0, 0);
    check5("reset_val5", 4'd5);
    reset = 1'b1;

    // Basic up count with wrap.
    for (int i = 1; i <= 9; i++) drv("up_step1", 1, 1, 1, 0, 0, 0, 0, i, 0, 0, 0, 0);
    drv("up_wrap",     1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    drv("after_wrap",  1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    drv("to_two",      1, 1, 1, 0, 0, 0, 0, 2, 0, 0, 1, 0);
    // Down wrap with step 3.
    drv("down_wrap",   1, 0, 3, 0, 0, 0, 0, 9, 0, 1, 1, 1);
    drv("down_step3",  1, 0, 3, 0, 0, 0, 0, 6, 0, 0, 1, 1);
    // Saturate mode.
    drv("load8",       0, 0, 0, 1, 1, 8, 0, 8, 0, 0, 1, 1);
    drv("sat_up",      1, 1, 3, 1, 0, 0, 0, 9, 1, 0, 1, 1);
    drv("sat_up_hold", 1, 1, 3, 1, 0, 0, 0, 9, 1, 0, 1, 1);
    drv("load3",       0, 0, 0, 1, 1, 3, 0, 3, 0, 0, 1, 1);
    drv("sat_down",    1, 0, 5, 1, 0, 0, 0, 0, 0, 1, 1, 1);
    drv("step_clamp",  1, 1, 15, 0, 0, 0, 0, 9, 0, 0, 1, 1);
    // Load behaviour.
    drv("load_clamp",  1, 1, 3, 0, 1, 12, 0, 9, 0, 0, 1, 1);
    drv("load4",       1, 0, 7, 0, 1, 4, 0, 4, 0, 0, 1, 1);
    // Sticky clear and set-wins race.
    drv("clr_alone",   0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0);
    drv("clr_race",    1, 1, 7, 0, 0, 0, 1, 1, 1, 0, 1, 0);
    drv("hold_en0",    0, 1, 7, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    drv("step0_up",    1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
    drv("step0_down",  1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    drv("down_clamp",  1, 0, 15, 0, 0, 0, 0, 2, 0, 1, 1, 1);
    drv("load7",       0, 0, 0, 0, 1, 7, 0, 7, 0, 0, 1, 1);

    // Asynchronous reset between edges.
    @(negedge clk);
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    check_state("async_reset", 4'd0, 0, 0, 0, 0);
    check5("async_reset5", 4'd5);
    @(posedge clk);
    #1;
    check_state("reset_held", 4'd0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    drv("resume1", 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    drv("resume2", 1, 1, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    @(negedge clk);
    idle_inputs();

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/up_down_counter_mod.md
Name: up_down_counter_mod

Overview:
Parametrised successor to the basic up/down counter. Adds a programmable modulus, variable step, wrap or saturate mode, synchronous load, count enable, boundary status, and overflow/underflow event and sticky flags. It is used as a general-purpose event, address or timer counter wherever a plain free-running up/down count is not enough.

Parameters:
WIDTH, 4, bit width of count, load_val and step.
MOD_MAX, 2**WIDTH-1, largest count value. Legal range 1..2**WIDTH-1. The count range is 0..MOD_MAX.
RESET_VAL, 0, count value after reset. Must be <= MOD_MAX.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset).
en  input  1  count enable; 0 holds count.
upordown  input  1  direction: 1 = up, 0 = down.
step  input  WIDTH  increment/decrement amount per enabled cycle.
sat_mode  input  1  boundary handling: 1 = saturate, 0 = wrap.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  value to load.
clr_flags  input  1  synchronous clear of the sticky flags.
count  output  WIDTH  current count (registered).
at_max  output  1  combinational: count == MOD_MAX.
at_min  output  1  combinational: count == 0.
ovf  output  1  registered one-cycle pulse on an up-boundary crossing.
unf  output  1  registered one-cycle pulse on a down-boundary crossing.
ovf_sticky  output  1  latched ovf.
unf_sticky  output  1  latched unf.

Behaviour:
- Reset (reset=0, asynchronous, no clock edge needed): count=RESET_VAL; ovf, unf, ovf_sticky and unf_sticky all 0. Reset takes effect immediately, including in the middle of operation. The first update occurs on the first rising clk edge after reset goes to 1.
- Priority per edge: load > en > hold.
- Load (load=1):
  - count <= min(load_val, MOD_MAX).
  - ovf and unf are 0 in the following cycle.
  - Direction, step and en are ignored in that cycle.
- Effective step: s = min(step, MOD_MAX). When s = 0 with en=1, count holds and no events fire.
- Arithmetic is done at WIDTH+1 bits so that no intermediate result truncates.
- Up (en=1, upordown=1):
  - If count + s <= MOD_MAX: count <= count + s.
  - Otherwise:
    - wrap mode: count <= count + s - (MOD_MAX+1).
    - saturate mode: count <= MOD_MAX.
    - In both modes, ovf=1 in the next cycle.
  - Special case: in saturate mode with count already at MOD_MAX and s > 0, the count stays at MOD_MAX and ovf still pulses.
- Down (en=1, upordown=0):
  - If s <= count: count <= count - s.
  - Otherwise:
    - wrap mode: count <= count + (MOD_MAX+1) - s.
    - saturate mode: count <= 0.
    - In both modes, unf=1 in the next cycle.
- Event pulse timing: ovf and unf are registered. They are high for exactly the one cycle in which count shows the post-crossing value, and are 0 on any cycle without a crossing. ovf and unf are never both 1.
- Sticky flags:
  - ovf_sticky is set when ovf is being set; unf_sticky likewise for unf.
  - clr_flags=1 clears both on the edge.
  - If a new event and clr_flags occur on the same edge, set wins and the flag reads 1.
- Direction, step and mode may change on any cycle. Each edge uses the values sampled at that edge; there is no pipeline and the count has one-cycle latency.
- at_max and at_min decode the registered count only (no input dependency). When MOD_MAX is in range, both can never be 1 together.

Test Plan:
Unless stated otherwise: WIDTH=4, MOD_MAX=9, RESET_VAL=0.

1. Reset and basic up count. Hold reset=0 for 2 cycles, then release with en=1, upordown=1, step=1, sat_mode=0.
   -> count sequence is 0,1,...,9,0.
   -> at_max=1 while count=9.
   -> ovf=1 only in the cycle where count returns to 0; ovf_sticky=1 afterwards.
2. Down wrap with step. From count=2, set upordown=0, step=3, wrap mode.
   -> count goes to 9 (2+10-3), then 6.
   -> unf pulses once, together with count=9; unf_sticky=1.
3. Saturate mode. sat_mode=1; load 8, then step=3 up.
   -> count=9 with ovf=1; the next enabled cycle holds 9 and ovf=1 again.
   -> Down with step=5 from 3 -> count=0, unf=1.
4. Load behaviour. load=1 with load_val=12 and en=1 -> count=9 (clamped), ovf=0.
   -> load=1 with load_val=4 -> count=4, regardless of en and step.
5. Sticky-flag clear race. With ovf_sticky=1, assert clr_flags alone -> flag 0.
   -> Then assert clr_flags on the same edge as a wrap event -> ovf_sticky=1.
6. Asynchronous reset mid-count. With count=7, drive reset=0 between clock edges.
   -> count=0 and all flags 0 immediately, without waiting for an edge.
   -> Counting resumes from 0 after release.
   -> Repeat with RESET_VAL=5: count=5 immediately on reset.
